// File: rtl/board_clear_sequencer.sv
// Line-clear sequencer for one player's board RAM. Scans bottom-up, removes full
// rows, compacts survivors downward and zero-fills the vacated top rows.
module board_clear_sequencer #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int DW   = 3
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          start,
    input  logic          hen,
    input  logic          ven,
    output logic          ram_own,
    output logic [7:0]    ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          done,
    output logic [4:0]    lines
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WR,
        CLR,
        DONE
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [3:0] END_COL  = 4'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t        state;
    state_t        state_nx;

    logic          win;
    logic [4:0]    src;
    logic          src_ex;
    logic [4:0]    dst;
    logic          dst_ex;
    logic [3:0]    col;
    logic [DW-1:0] rowbuf [COLS];
    logic [4:0]    cnt;
    logic          rd_pend;
    logic [3:0]    rd_idx;

    logic          row_full;
    logic          rd_issue;
    logic          rd_last;
    logic          wr_step;
    logic          wr_last;
    logic          go_wr;
    logic          adv_src;
    logic          adv_dst;
    logic          src_ex_a;
    logic          dst_ex_a;
    state_t        after_row;
    logic [4:0]    row_sel;

    // Decode of the access window and the per-row step/exit conditions.
    always_comb begin
        win      = !(hen && ven);
        row_full = 1'b1;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (rowbuf[i] == '0) begin
                row_full = 1'b0;
            end
        end
        rd_issue = (state == RD) && win && (col != END_COL);
        rd_last  = (state == RD) && rd_pend && (rd_idx == LAST_COL);
        wr_step  = ((state == WR) || (state == CLR)) && win;
        wr_last  = wr_step && (col == LAST_COL);
        go_wr    = (state == CHK) && !row_full && (src != dst);
        adv_src  = ((state == CHK) && !go_wr) || ((state == WR) && wr_last);
        adv_dst  = ((state == CHK) && !row_full && !go_wr) || ((state == WR) && wr_last);
        src_ex_a = adv_src ? (src == '0) : src_ex;
        dst_ex_a = adv_dst ? (dst == '0) : dst_ex;
        if (!src_ex_a) begin
            after_row = RD;
        end else if (!dst_ex_a) begin
            after_row = CLR;
        end else begin
            after_row = DONE;
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RD;
            RD:   if (rd_last) state_nx = CHK;
            CHK:  state_nx = go_wr ? WR : after_row;
            WR:   if (wr_last) state_nx = after_row;
            CLR:  if (wr_last && (dst == '0)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            src     <= '0;
            src_ex  <= 1'b0;
            dst     <= '0;
            dst_ex  <= 1'b0;
            col     <= '0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            lines   <= '0;
            for (int unsigned i = 0; i < COLS; i++) begin
                rowbuf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src     <= LAST_ROW;
                        dst     <= LAST_ROW;
                        src_ex  <= 1'b0;
                        dst_ex  <= 1'b0;
                        cnt     <= '0;
                        col     <= '0;
                        rd_pend <= 1'b0;
                    end
                end
                RD: begin
                    // Capture is unconditional: data belongs to the read issued last cycle.
                    rd_pend <= rd_issue;
                    if (rd_issue) begin
                        rd_idx <= col;
                        col    <= col + 4'd1;
                    end
                    if (rd_pend) begin
                        rowbuf[rd_idx] <= ram_rdata;
                    end
                    if (rd_last) begin
                        col <= '0;
                    end
                end
                CHK: begin
                    col <= '0;
                    if (row_full) begin
                        cnt <= cnt + 5'd1;
                    end
                end
                WR: begin
                    if (wr_step) begin
                        col <= wr_last ? '0 : col + 4'd1;
                    end
                end
                CLR: begin
                    if (wr_last) begin
                        col <= '0;
                        dst <= dst - 5'd1;
                    end else if (wr_step) begin
                        col <= col + 4'd1;
                    end
                end
                DONE: begin
                    lines <= cnt;
                end
                default: ;
            endcase
            if (adv_src) begin
                src    <= src - 5'd1;
                src_ex <= (src == '0);
            end
            if (adv_dst) begin
                dst    <= dst - 5'd1;
                dst_ex <= (dst == '0);
            end
        end
    end

    always_comb begin
        busy      = (state == RD) || (state == CHK) || (state == WR) || (state == CLR);
        done      = (state == DONE);
        ram_own   = busy && win;
        ram_we    = wr_step;
        ram_wdata = '0;
        ram_addr  = '0;
        row_sel   = (state == RD) ? src : dst;
        if (state == WR) begin
            ram_wdata = rowbuf[col];
        end
        if (((state == RD) && (col != END_COL)) || (state == WR) || (state == CLR)) begin
            ram_addr = 8'(row_sel) * 8'(COLS) + 8'(col);
        end
    end

endmodule

// File: tb/tb_board_clear_sequencer.sv
// Directed bench for board_clear_sequencer with a behavioural registered-read board RAM.
module tb_board_clear_sequencer;

    logic       pclk = 1'b0;
    logic       rstn;
    logic       start;
    logic       hen;
    logic       ven;
    logic       ram_own;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;
    logic       busy;
    logic       done;
    logic [4:0] lines;

    logic [2:0] mem   [200];
    logic [2:0] exp_b [200];
    bit         rdmap [200];

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int writes   = 0;
    bit gate     = 1'b0;
    int phase    = 0;

    board_clear_sequencer #(.COLS(10), .ROWS(20), .DW(3)) dut (
        .pclk      (pclk),
        .rstn      (rstn),
        .start     (start),
        .hen       (hen),
        .ven       (ven),
        .ram_own   (ram_own),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .done      (done),
        .lines     (lines)
    );

    always #5 pclk = ~pclk;

    // Board RAM; when the display owns the port it returns nonzero junk.
    always @(posedge pclk) begin
        if (ram_own && ram_we && ram_addr < 8'd200) mem[ram_addr] <= ram_wdata;
        if (ram_own && ram_addr < 8'd200) ram_rdata <= mem[ram_addr];
        else ram_rdata <= 3'b111;
    end

    task automatic step();
        @(posedge pclk);
        #1;
        if (gate) begin
            phase = (phase + 1) % 1056;
            hen = (phase < 800);
            ven = (phase < 800);
        end else begin
            hen = 1'b0;
            ven = 1'b0;
        end
        #1;
        if (hen && ven && (ram_own || ram_we)) viol++;
        if (ram_we && !ram_own) viol++;
        if (ram_we && ram_addr >= 8'd200) viol++;
        if (ram_we) writes++;
        if (ram_own && !ram_we && ram_addr < 8'd200) rdmap[ram_addr] = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            step();
            start = 1'b0;
            cyc++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_pass(input int budget, output int cyc, output bit ok, output bit post);
        start = 1'b1;
        wait_done(budget, cyc, ok);
        step();
        post = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 200; i++) begin
            mem[i]   = 3'd0;
            exp_b[i] = 3'd0;
            rdmap[i] = 1'b0;
        end
        writes = 0;
        viol   = 0;
    endtask

    task automatic fill_row(input int r, input bit pat);
        for (int c = 0; c < 10; c++) mem[r*10+c] = pat ? 3'((c % 7) + 1) : 3'b010;
    endtask

    function automatic int board_diff();
        int n = 0;
        for (int i = 0; i < 200; i++) if (mem[i] !== exp_b[i]) n++;
        return n;
    endfunction

    task automatic load_s2();
        clear_all();
        fill_row(19, 1'b0);
        mem[180] = 3'd1;
        exp_b[190] = 3'd1;
    endtask

    task automatic load_s4();
        clear_all();
        fill_row(19, 1'b1);
        fill_row(17, 1'b1);
        mem[180] = 3'd5;
        mem[162] = 3'd6;
        exp_b[190] = 3'd5;
        exp_b[182] = 3'd6;
    endtask

    task automatic test_reset();
        rstn = 1'b1; start = 1'b0; hen = 1'b0; ven = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) step();
        checks++;
        if ({ram_own, ram_we, busy, done} !== 4'b0000)
            begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {ram_own, ram_we, busy, done}); end
        checks++;
        if (ram_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", ram_addr); end
        checks++;
        if (ram_wdata !== 3'd0) begin failures++; $display("FAIL reset_wdata got=%0d want=0", ram_wdata); end
        checks++;
        if (lines !== 5'd0) begin failures++; $display("FAIL reset_lines got=%0d want=0", lines); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_empty();
        int cyc, nrd; bit ok, post;
        clear_all();
        run_pass(300, cyc, ok, post);
        nrd = 0;
        for (int i = 0; i < 200; i++) if (rdmap[i]) nrd++;
        checks++; if (!ok) begin failures++; $display("FAIL empty_done got=timeout want=done"); end
        checks++; if (cyc > 245) begin failures++; $display("FAIL empty_latency got=%0d want<=245", cyc); end
        checks++; if (lines !== 5'd0) begin failures++; $display("FAIL empty_lines got=%0d want=0", lines); end
        checks++; if (writes !== 0) begin failures++; $display("FAIL empty_writes got=%0d want=0", writes); end
        checks++; if (nrd !== 200) begin failures++; $display("FAIL empty_reads got=%0d want=200", nrd); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL empty_board got=%0d bad cells want=0", board_diff()); end
        checks++; if (post !== 1'b1) begin failures++; $display("FAIL empty_done_pulse got=stuck want=one cycle"); end
    endtask

    task automatic test_single_full();
        int cyc; bit ok, post;
        load_s2();
        run_pass(1000, cyc, ok, post);
        checks++; if (!ok) begin failures++; $display("FAIL s2_done got=timeout want=done"); end
        checks++; if (lines !== 5'd1) begin failures++; $display("FAIL s2_lines got=%0d want=1", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL s2_board got=%0d bad cells want=0", board_diff()); end
        // 19 surviving rows shifted down by one, plus row 0 cleared
        checks++; if (writes !== 200) begin failures++; $display("FAIL s2_writes got=%0d want=200", writes); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL s2_port got=%0d violations want=0", viol); end
    endtask

    task automatic test_quad();
        int cyc; bit ok, post;
        clear_all();
        for (int r = 16; r < 20; r++) fill_row(r, 1'b1);
        for (int c = 0; c < 9; c++) begin
            mem[150+c]   = 3'd7;
            exp_b[190+c] = 3'd7;
        end
        run_pass(1000, cyc, ok, post);
        checks++; if (!ok) begin failures++; $display("FAIL s3_done got=timeout want=done"); end
        checks++; if (lines !== 5'd4) begin failures++; $display("FAIL s3_lines got=%0d want=4", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL s3_board got=%0d bad cells want=0", board_diff()); end
        checks++; if (writes !== 200) begin failures++; $display("FAIL s3_writes got=%0d want=200", writes); end
    endtask

    task automatic test_noncontig();
        int cyc; bit ok, post;
        load_s4();
        run_pass(1000, cyc, ok, post);
        checks++; if (!ok) begin failures++; $display("FAIL s4_done got=timeout want=done"); end
        checks++; if (lines !== 5'd2) begin failures++; $display("FAIL s4_lines got=%0d want=2", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL s4_board got=%0d bad cells want=0", board_diff()); end
        checks++; if (writes !== 200) begin failures++; $display("FAIL s4_writes got=%0d want=200", writes); end
    endtask

    task automatic test_gating();
        int cyc; bit ok, post;
        load_s2();
        gate = 1'b1;
        phase = 0;
        run_pass(6000, cyc, ok, post);
        gate = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL gate_done got=timeout want=done"); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL gate_port got=%0d violations want=0", viol); end
        checks++; if (lines !== 5'd1) begin failures++; $display("FAIL gate_lines got=%0d want=1", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL gate_board got=%0d bad cells want=0", board_diff()); end
        checks++; if (writes !== 200) begin failures++; $display("FAIL gate_writes got=%0d want=200", writes); end
    endtask

    task automatic test_start_busy();
        int cyc; bit ok;
        load_s4();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid got=%b want=1", busy); end
        checks++; if (lines !== 5'd1) begin failures++; $display("FAIL busy_lines_held got=%0d want=1", lines); end
        wait_done(1000, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL busy_done got=timeout want=done"); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_done got=busy=%b want=0", busy); end
        checks++; if (lines !== 5'd2) begin failures++; $display("FAIL busy_lines got=%0d want=2", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL busy_board got=%0d bad cells want=0", board_diff()); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok, post, seen;
        load_s2();
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            start = 1'b0;
            if (ram_we === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_reach_wr got=no write want=write"); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, ram_own, ram_we} !== 3'b000)
            begin failures++; $display("FAIL rst_async got=%b want=000", {busy, ram_own, ram_we}); end
        checks++; if (lines !== 5'd0) begin failures++; $display("FAIL rst_lines got=%0d want=0", lines); end
        step();
        rstn = 1'b1;
        step();
        load_s2();
        run_pass(1000, cyc, ok, post);
        checks++; if (!ok) begin failures++; $display("FAIL rst_fresh_done got=timeout want=done"); end
        checks++; if (lines !== 5'd1) begin failures++; $display("FAIL rst_fresh_lines got=%0d want=1", lines); end
        checks++; if (board_diff() !== 0) begin failures++; $display("FAIL rst_fresh_board got=%0d bad cells want=0", board_diff()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=no finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_empty();
        test_single_full();
        test_quad();
        test_noncontig();
        test_gating();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
